elevator_call_scheduler: RTL and testbench

Request-side scheduler for the elevator FSM. It latches hall/cab call buttons for three floors and watches the `floor` feedback from `elevator_controller`. It issues single-cycle `up_request`/`down_request` pulses to move the car one floor at a time toward pending calls, then holds a timed door-open phase at each served floor. It sits between the button inputs and `elevator_controller`, and is the initiator of that block's request interface.

---
 rtl/elevator_call_scheduler.sv | 130 +++++++++++++
 tb/tb_elevator_call_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// Call scheduler for a three-floor car: latches call buttons, steps the car one floor at a
// time through elevator_controller, and holds a timed door phase at each served floor.
module elevator_call_scheduler #(
  parameter int unsigned DOOR_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] call_btn,
  input  logic [1:0] floor,
  output logic       up_request,
  output logic       down_request,
  output logic       door_open,
  output logic [2:0] pending,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [2:0] {IDLE, REQ_UP, REQ_DOWN, WAIT, DOOR, HALT} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);

  state_t        state, state_nxt;
  dir_t          dir, dir_nxt;
  logic [1:0]    target, target_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic [DW-1:0] door_cnt, door_cnt_nxt;
  logic [2:0]    floor_oh, clr, btn_mask, pending_nxt;
  logic          calls_above, calls_below;

  always_comb begin
    floor_oh    = '0;
    calls_above = 1'b0;
    calls_below = 1'b0;
    case (floor)
      2'd0: begin
        floor_oh    = 3'b001;
        calls_above = |pending[2:1];
      end
      2'd1: begin
        floor_oh    = 3'b010;
        calls_above = pending[2];
        calls_below = pending[0];
      end
      2'd2: begin
        floor_oh    = 3'b100;
        calls_below = |pending[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    dir_nxt      = dir;
    target_nxt   = target;
    wait_cnt_nxt = wait_cnt;
    door_cnt_nxt = door_cnt;
    clr          = '0;
    case (state)
      IDLE: begin
        if (floor == 2'b11) begin
          state_nxt = HALT;
        end else if (|(pending & floor_oh)) begin
          state_nxt    = DOOR;
          clr          = floor_oh;
          door_cnt_nxt = '0;
        end else if ((dir == DIR_UP && calls_above) || (dir == DIR_DOWN && calls_above && !calls_below)) begin
          state_nxt  = REQ_UP;
          dir_nxt    = DIR_UP;
          target_nxt = floor + 2'd1;
        end else if (calls_below) begin
          state_nxt  = REQ_DOWN;
          dir_nxt    = DIR_DOWN;
          target_nxt = floor - 2'd1;
        end
      end
      REQ_UP, REQ_DOWN: begin
        state_nxt    = WAIT;
        wait_cnt_nxt = '0;
      end
      WAIT: begin
        if (floor == target) begin
          state_nxt = IDLE;
        end else if (wait_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      DOOR: begin
        if (door_cnt == DW'(DOOR_CYCLES - 1)) state_nxt = IDLE;
        else door_cnt_nxt = door_cnt + 1'b1;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // A press at the floor being served is swallowed so the door phase does not re-arm it.
  assign btn_mask    = (state == DOOR) ? floor_oh : '0;
  assign pending_nxt = (pending | (call_btn & ~btn_mask)) & ~clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dir      <= DIR_UP;
      target   <= '0;
      wait_cnt <= '0;
      door_cnt <= '0;
      pending  <= '0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      target   <= target_nxt;
      wait_cnt <= wait_cnt_nxt;
      door_cnt <= door_cnt_nxt;
      pending  <= pending_nxt;
    end
  end

  assign up_request   = (state == REQ_UP);
  assign down_request = (state == REQ_DOWN);
  assign door_open    = (state == DOOR);
  assign busy         = (state != IDLE);
  assign fault        = (state == HALT);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: a simple car model answers requests; a monitor turns
// request pulses and door phases into event codes checked against a queue of expectations.
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] call_btn = '0;
  logic [1:0] floor;
  logic       up_request, down_request, door_open, busy, fault;
  logic [2:0] pending;

  logic [1:0] model_floor = '0;
  logic       preset_en = 1'b0;
  logic [1:0] preset_val = '0;
  logic       stub_hold = 1'b0;
  logic       force_bad = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_q[$];
  int test_id = 0;

  elevator_call_scheduler #(.DOOR_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .call_btn(call_btn), .floor(floor),
    .up_request(up_request), .down_request(down_request), .door_open(door_open),
    .pending(pending), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  assign floor = force_bad ? 2'b11 : model_floor;

  always @(posedge clk) begin
    if (preset_en) model_floor <= preset_val;
    else if (!stub_hold && !force_bad) begin
      if (up_request) model_floor <= model_floor + 2'd1;
      else if (down_request) model_floor <= model_floor - 2'd1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // kind: 0 up pulse, 1 down pulse, 2 door phase; gap = cycles since previous request start
  function automatic int evt(input int kind, input int fl, input int width, input int gap);
    return kind * 10000 + fl * 1000 + width * 100 + gap;
  endfunction

  task automatic emit(input int code);
    if (exp_q.size() == 0) check_eq("unexpected_evt", code, -1);
    else check_eq("evt", code, exp_q.pop_front());
  endtask

  int cyc = 0, last_req = -1, seen_test = 0;
  logic prev_up = 1'b0, prev_dn = 1'b0, prev_door = 1'b0;
  int up_f, up_w, up_g, dn_f, dn_w, dn_g, door_f, door_w;

  always @(negedge clk) begin
    cyc++;
    if (seen_test != test_id) begin
      seen_test = test_id;
      last_req  = -1;
    end
    check_eq("req_exclusive", int'(up_request & down_request), 0);
    if (up_request && !prev_up) begin
      up_f = int'(floor); up_w = 0;
      up_g = (last_req < 0) ? 0 : cyc - last_req;
      last_req = cyc;
    end
    if (up_request) up_w++;
    if (!up_request && prev_up) emit(evt(0, up_f, up_w, up_g));
    if (down_request && !prev_dn) begin
      dn_f = int'(floor); dn_w = 0;
      dn_g = (last_req < 0) ? 0 : cyc - last_req;
      last_req = cyc;
    end
    if (down_request) dn_w++;
    if (!down_request && prev_dn) emit(evt(1, dn_f, dn_w, dn_g));
    if (door_open && !prev_door) begin
      door_f = int'(floor); door_w = 0;
    end
    if (door_open) door_w++;
    if (!door_open && prev_door) emit(evt(2, door_f, door_w, 0));
    prev_up   = up_request;
    prev_dn   = down_request;
    prev_door = door_open;
  end

  task automatic do_reset(input logic [1:0] f);
    @(negedge clk);
    reset_n = 1'b0; stub_hold = 1'b0; force_bad = 1'b0; call_btn = '0;
    preset_en = 1'b1; preset_val = f;
    repeat (2) @(negedge clk);
    preset_en = 1'b0;
    reset_n = 1'b1;
    test_id++;
  endtask

  task automatic press(input logic [2:0] v);
    @(negedge clk);
    call_btn = v;
    @(negedge clk);
    call_btn = '0;
  endtask

  task automatic finish_test(input string tag);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check_eq({tag, "_idle"}, int'(busy), 0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_events_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_up", int'(up_request), 0);
    check_eq("rst_down", int'(down_request), 0);
    check_eq("rst_door", int'(door_open), 0);
    check_eq("rst_pending", int'(pending), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_fault", int'(fault), 0);

    // single call up: 00 -> 10
    do_reset(2'd0);
    exp_q.push_back(evt(0, 0, 1, 0));
    exp_q.push_back(evt(0, 1, 1, 3));
    exp_q.push_back(evt(2, 2, 4, 0));
    press(3'b100);
    check_eq("t1_pending_latched", int'(pending), 4);
    for (int i = 0; i < 50 && !door_open; i++) @(negedge clk);
    check_eq("t1_door_seen", int'(door_open), 1);
    check_eq("t1_pending_cleared", int'(pending), 0);
    finish_test("t1");
    check_eq("t1_floor", int'(floor), 2);

    // call at current floor
    do_reset(2'd0);
    exp_q.push_back(evt(2, 0, 4, 0));
    press(3'b001);
    check_eq("t2_pending", int'(pending), 1);
    check_eq("t2_door_early", int'(door_open), 0);
    @(negedge clk);
    check_eq("t2_door_entry", int'(door_open), 1);
    check_eq("t2_pending_clr", int'(pending), 0);
    press(3'b001);
    check_eq("t2_masked", int'(pending), 0);
    finish_test("t2");

    // direction preference from floor 01
    do_reset(2'd1);
    exp_q.push_back(evt(0, 1, 1, 0));
    exp_q.push_back(evt(2, 2, 4, 0));
    exp_q.push_back(evt(1, 2, 1, 8));
    exp_q.push_back(evt(1, 1, 1, 3));
    exp_q.push_back(evt(2, 0, 4, 0));
    press(3'b101);
    check_eq("t3_pending", int'(pending), 5);
    for (int i = 0; i < 100 && !(busy == 1'b0 && pending == 3'b000); i++) @(negedge clk);
    finish_test("t3");
    check_eq("t3_pending_final", int'(pending), 0);
    check_eq("t3_floor", int'(floor), 0);

    // timeout with a stuck car
    do_reset(2'd0);
    stub_hold = 1'b1;
    exp_q.push_back(evt(0, 0, 1, 0));
    press(3'b010);
    for (int i = 0; i < 20 && !up_request; i++) @(negedge clk);
    check_eq("t4_up_seen", int'(up_request), 1);
    begin
      int n = 0;
      while (!fault && n < 30) begin
        @(negedge clk);
        n++;
      end
      check_eq("t4_fault_delay", n, 9);
    end
    repeat (5) @(negedge clk);
    press(3'b100);
    check_eq("t4_pending", int'(pending), 6);
    check_eq("t4_busy", int'(busy), 1);
    check_eq("t4_fault", int'(fault), 1);
    check_eq("t4_door", int'(door_open), 0);
    check_eq("t4_events_left", exp_q.size(), 0);
    exp_q.delete();

    // invalid floor code in IDLE
    do_reset(2'd0);
    @(negedge clk);
    force_bad = 1'b1;
    check_eq("t5_fault_before", int'(fault), 0);
    @(negedge clk);
    check_eq("t5_fault", int'(fault), 1);
    check_eq("t5_busy", int'(busy), 1);
    force_bad = 1'b0;

    // asynchronous reset during an up_request
    do_reset(2'd0);
    exp_q.push_back(evt(0, 0, 1, 0));
    press(3'b100);
    for (int i = 0; i < 20 && !up_request; i++) @(negedge clk);
    check_eq("t6_up_seen", int'(up_request), 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_up_drop", int'(up_request), 0);
    check_eq("t6_pending_drop", int'(pending), 0);
    check_eq("t6_door_drop", int'(door_open), 0);
    check_eq("t6_fault_drop", int'(fault), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t6_quiet_busy", int'(busy), 0);
    check_eq("t6_quiet_pending", int'(pending), 0);
    check_eq("t6_events_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
